// File: rtl/ex_mem_if.sv
// ex_mem_if -- EX-to-MEM pipeline boundary bundle.
//   EX side    : ex_valid/ex_ready handshake plus the EX payload and branch info.
//   MEM side   : mem_valid/mem_ready handshake plus the registered payload.
//   Redirect   : redirect_valid/redirect_pc one-cycle fetch redirect.
//   Forwarding : fwd_valid/fwd_rd/fwd_data source for the EX operand muxes.
// modport slave is taken by the stage; modport master by whatever drives EX and MEM.
interface ex_mem_if;
   logic        ex_valid;
   logic        ex_ready;
   logic [31:0] ex_alu_result;
   logic        ex_zero;
   logic [31:0] ex_rs2_data;
   logic [4:0]  ex_rd;
   logic        ex_reg_write;
   logic        ex_mem_read;
   logic        ex_mem_write;
   logic        ex_branch;
   logic        ex_branch_ne;
   logic [31:0] ex_branch_target;

   logic        mem_ready;
   logic        mem_valid;
   logic [31:0] mem_alu_result;
   logic [31:0] mem_rs2_data;
   logic [4:0]  mem_rd;
   logic        mem_reg_write;
   logic        mem_mem_read;
   logic        mem_mem_write;

   logic        redirect_valid;
   logic [31:0] redirect_pc;

   logic        fwd_valid;
   logic [4:0]  fwd_rd;
   logic [31:0] fwd_data;

   modport slave (
      input  ex_valid, ex_alu_result, ex_zero, ex_rs2_data, ex_rd,
             ex_reg_write, ex_mem_read, ex_mem_write,
             ex_branch, ex_branch_ne, ex_branch_target, mem_ready,
      output ex_ready, mem_valid, mem_alu_result, mem_rs2_data, mem_rd,
             mem_reg_write, mem_mem_read, mem_mem_write,
             redirect_valid, redirect_pc, fwd_valid, fwd_rd, fwd_data
   );

   modport master (
      output ex_valid, ex_alu_result, ex_zero, ex_rs2_data, ex_rd,
             ex_reg_write, ex_mem_read, ex_mem_write,
             ex_branch, ex_branch_ne, ex_branch_target, mem_ready,
      input  ex_ready, mem_valid, mem_alu_result, mem_rs2_data, mem_rd,
             mem_reg_write, mem_mem_read, mem_mem_write,
             redirect_valid, redirect_pc, fwd_valid, fwd_rd, fwd_data
   );
endinterface

// File: rtl/ex_mem_stage.sv
// ex_mem_stage -- EX/MEM pipeline register with branch resolution and squash.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : ex_mem_if.slave (EX handshake/payload in, MEM payload out,
//           fetch redirect out, forwarding source out)
// A taken BEQ/BNE pulses redirect for one cycle and the next SQUASH_DEPTH
// accepted transfers are discarded (accepted but presented with mem_valid=0).
module ex_mem_stage #(
   parameter int SQUASH_DEPTH = 2
) (
   input  logic     clk,
   input  logic     rst_n,
   ex_mem_if.slave  bus
);

   typedef enum logic {RUN = 1'b0, SQUASH = 1'b1} state_t;

   localparam logic [1:0] DEPTH = 2'(SQUASH_DEPTH);

   state_t      state_q, state_d;
   logic [1:0]  cnt_q, cnt_d;
   logic        xfer, squashed, taken;

   logic        vld_p1;
   logic [31:0] alu_result_p1;
   logic [31:0] rs2_data_p1;
   logic [4:0]  rd_p1;
   logic        reg_write_p1, mem_read_p1, mem_write_p1;
   logic        redirect_vld_p1;
   logic [31:0] redirect_pc_p1;

   // ---- p0: handshake and branch resolution (combinational, EX side) ----
   assign bus.ex_ready = bus.mem_ready | ~vld_p1;
   assign xfer         = bus.ex_valid & bus.ex_ready;
   assign squashed     = (state_q == SQUASH);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      taken   = 1'b0;
      if (xfer) begin
         if (squashed) begin
            // A branch in a squashed slot is dropped: no redirect, no re-arm.
            if (cnt_q <= 2'd1) begin
               state_d = RUN;
               cnt_d   = 2'd0;
            end else begin
               cnt_d = cnt_q - 2'd1;
            end
         end else begin
            taken = bus.ex_branch & (bus.ex_zero ^ bus.ex_branch_ne);
            if (taken && DEPTH != 2'd0) begin
               state_d = SQUASH;
               cnt_d   = DEPTH;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RUN;
         cnt_q   <= 2'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // ---- p1: EX/MEM register ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1          <= 1'b0;
         alu_result_p1   <= '0;
         rs2_data_p1     <= '0;
         rd_p1           <= '0;
         reg_write_p1    <= 1'b0;
         mem_read_p1     <= 1'b0;
         mem_write_p1    <= 1'b0;
         redirect_vld_p1 <= 1'b0;
         redirect_pc_p1  <= '0;
      end else begin
         redirect_vld_p1 <= xfer & taken;
         if (xfer && taken)
            redirect_pc_p1 <= bus.ex_branch_target;
         if (xfer) begin
            vld_p1        <= ~squashed;
            alu_result_p1 <= bus.ex_alu_result;
            rs2_data_p1   <= bus.ex_rs2_data;
            rd_p1         <= bus.ex_rd;
            reg_write_p1  <= bus.ex_reg_write;
            mem_read_p1   <= bus.ex_mem_read;
            mem_write_p1  <= bus.ex_mem_write;
         end else if (bus.mem_ready) begin
            vld_p1 <= 1'b0;
         end
      end
   end

   assign bus.mem_valid      = vld_p1;
   assign bus.mem_alu_result = alu_result_p1;
   assign bus.mem_rs2_data   = rs2_data_p1;
   assign bus.mem_rd         = rd_p1;
   assign bus.mem_reg_write  = reg_write_p1;
   assign bus.mem_mem_read   = mem_read_p1;
   assign bus.mem_mem_write  = mem_write_p1;
   assign bus.redirect_valid = redirect_vld_p1;
   assign bus.redirect_pc    = redirect_pc_p1;

   // x0 is never a forwarding source even though it travels down the pipe.
   assign bus.fwd_valid = vld_p1 & reg_write_p1 & (rd_p1 != 5'd0);
   assign bus.fwd_rd    = rd_p1;
   assign bus.fwd_data  = alu_result_p1;

endmodule

// File: tb/tb_ex_mem_stage.sv
// tb_ex_mem_stage -- directed scenarios plus randomized traffic for ex_mem_stage,
// compared each cycle against a transaction-level reference model.
module tb_ex_mem_stage;

   localparam int DEPTH = 2;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   ex_mem_if bus ();

   ex_mem_stage #(.SQUASH_DEPTH(DEPTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: what MEM should currently see, plus remaining squash slots.
   logic        m_valid, m_rw, m_mr, m_mw, m_rv;
   logic [31:0] m_alu, m_rs2, m_rpc;
   logic [4:0]  m_rd;
   int          squash_left;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_rv = 0;
      m_alu = 0; m_rs2 = 0; m_rpc = 0; m_rd = 0;
      squash_left = 0;
   endtask

   task automatic drive(input logic v, input logic [31:0] alu, input logic zero,
                        input logic [31:0] rs2, input logic [4:0] rd,
                        input logic rw, input logic mr, input logic mw,
                        input logic br, input logic ne, input logic [31:0] tgt,
                        input logic mready);
      bus.ex_valid = v; bus.ex_alu_result = alu; bus.ex_zero = zero;
      bus.ex_rs2_data = rs2; bus.ex_rd = rd; bus.ex_reg_write = rw;
      bus.ex_mem_read = mr; bus.ex_mem_write = mw; bus.ex_branch = br;
      bus.ex_branch_ne = ne; bus.ex_branch_target = tgt; bus.mem_ready = mready;
   endtask

   task automatic rand_drive();
      drive($urandom_range(0, 3) != 0, $urandom, 1'($urandom), $urandom,
            5'($urandom_range(0, 7)), 1'($urandom), 1'($urandom), 1'($urandom),
            $urandom_range(0, 4) == 0, 1'($urandom), $urandom,
            $urandom_range(0, 3) != 0);
   endtask

   task automatic check_all();
      check("mem_valid", 32'(bus.mem_valid), 32'(m_valid));
      check("mem_alu", bus.mem_alu_result, m_alu);
      check("mem_rs2", bus.mem_rs2_data, m_rs2);
      check("mem_rd", 32'(bus.mem_rd), 32'(m_rd));
      check("mem_ctl", {29'd0, bus.mem_reg_write, bus.mem_mem_read, bus.mem_mem_write},
            {29'd0, m_rw, m_mr, m_mw});
      check("redirect_valid", 32'(bus.redirect_valid), 32'(m_rv));
      check("redirect_pc", bus.redirect_pc, m_rpc);
      check("fwd_valid", 32'(bus.fwd_valid), 32'(m_valid && m_rw && m_rd != 0));
      check("fwd_rd", 32'(bus.fwd_rd), 32'(m_rd));
      check("fwd_data", bus.fwd_data, m_alu);
      check("ex_ready", 32'(bus.ex_ready), 32'(bus.mem_ready || !m_valid));
   endtask

   // Advance one clock with the currently driven inputs, update the model, check.
   task automatic step();
      logic xfer, sq, tk;
      xfer = bus.ex_valid && (bus.mem_ready || !m_valid);
      if (xfer) begin
         sq = (squash_left > 0);
         tk = !sq && bus.ex_branch && (bus.ex_zero != bus.ex_branch_ne);
      end else begin
         sq = 0; tk = 0;
      end
      @(posedge clk);
      #1;
      if (xfer) begin
         m_valid = !sq;
         m_alu = bus.ex_alu_result; m_rs2 = bus.ex_rs2_data; m_rd = bus.ex_rd;
         m_rw = bus.ex_reg_write; m_mr = bus.ex_mem_read; m_mw = bus.ex_mem_write;
         if (tk) m_rpc = bus.ex_branch_target;
         if (sq) squash_left--;
         else if (tk) squash_left = DEPTH;
      end else if (bus.mem_ready) begin
         m_valid = 0;
      end
      m_rv = tk;
      check_all();
   endtask

   task automatic async_reset();
      rst_n = 0;
      #1;
      model_reset();
      check("rst mem_valid", 32'(bus.mem_valid), 32'd0);
      check("rst redirect", 32'(bus.redirect_valid), 32'd0);
      check_all();
      @(negedge clk);
      rst_n = 1;
   endtask

   task automatic alu_op(input logic [31:0] val, input logic [4:0] rd);
      drive(1, val, 0, 32'h0, rd, 1, 0, 0, 0, 0, 32'h0, 1);
      step();
   endtask

   initial begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      model_reset();
      rst_n = 0;
      #2;
      check("reset mem_valid", 32'(bus.mem_valid), 32'd0);
      check("reset redirect_pc", bus.redirect_pc, 32'd0);
      check_all();
      @(negedge clk);
      rst_n = 1;

      // ALU add forwarded to rd=3
      alu_op(32'h5, 5'd3);
      check("add fwd_valid", 32'(bus.fwd_valid), 32'd1);
      check("add fwd_rd", 32'(bus.fwd_rd), 32'd3);
      check("add fwd_data", bus.fwd_data, 32'd5);

      // x0 destination: passes through but never forwards
      alu_op(32'h77, 5'd0);
      check("x0 fwd_valid", 32'(bus.fwd_valid), 32'd0);
      check("x0 mem_valid", 32'(bus.mem_valid), 32'd1);

      // Stall three cycles with a new instruction waiting
      drive(1, 32'hAAAA_0001, 0, 32'h1234, 5'd9, 1, 0, 1, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         step();
         check("stall ex_ready", 32'(bus.ex_ready), 32'd0);
         check("stall hold alu", bus.mem_alu_result, 32'h77);
      end
      bus.mem_ready = 1;
      step();
      check("stall release alu", bus.mem_alu_result, 32'hAAAA_0001);

      // Taken BEQ, two squashed slots, third accepted
      drive(1, 0, 1, 0, 5'd0, 0, 0, 0, 1, 0, 32'h100, 1);
      step();
      check("beq redirect", 32'(bus.redirect_valid), 32'd1);
      check("beq pc", bus.redirect_pc, 32'h100);
      check("beq mem_valid", 32'(bus.mem_valid), 32'd1);
      alu_op(32'h11, 5'd4);
      check("sq1 mem_valid", 32'(bus.mem_valid), 32'd0);
      check("sq1 redirect", 32'(bus.redirect_valid), 32'd0);
      alu_op(32'h12, 5'd4);
      check("sq2 mem_valid", 32'(bus.mem_valid), 32'd0);
      alu_op(32'h13, 5'd4);
      check("after sq mem_valid", 32'(bus.mem_valid), 32'd1);

      // BNE with zero=1: not taken
      drive(1, 0, 1, 0, 5'd0, 0, 0, 0, 1, 1, 32'h200, 1);
      step();
      check("bne nt redirect", 32'(bus.redirect_valid), 32'd0);
      alu_op(32'h21, 5'd5);
      check("bne nt next", 32'(bus.mem_valid), 32'd1);

      // Taken branch then taken BNE in first squashed slot: one pulse, 2 slots
      drive(1, 0, 1, 0, 5'd0, 0, 0, 0, 1, 0, 32'h300, 1);
      step();
      check("br2 first pulse", 32'(bus.redirect_valid), 32'd1);
      drive(1, 0, 0, 0, 5'd0, 0, 0, 0, 1, 1, 32'h400, 1);
      step();
      check("br2 no pulse", 32'(bus.redirect_valid), 32'd0);
      check("br2 pc held", bus.redirect_pc, 32'h300);
      alu_op(32'h31, 5'd6);
      check("br2 sq2", 32'(bus.mem_valid), 32'd0);
      alu_op(32'h32, 5'd6);
      check("br2 done", 32'(bus.mem_valid), 32'd1);

      // Reset mid-squash with one slot left
      drive(1, 0, 1, 0, 5'd0, 0, 0, 0, 1, 0, 32'h500, 1);
      step();
      alu_op(32'h41, 5'd2);
      async_reset();
      alu_op(32'h42, 5'd7);
      check("post rst mem_valid", 32'(bus.mem_valid), 32'd1);
      check("post rst fwd_rd", 32'(bus.fwd_rd), 32'd7);

      // Randomized traffic with occasional asynchronous resets
      for (int i = 0; i < 3000; i++) begin
         rand_drive();
         if ($urandom_range(0, 199) == 0) async_reset();
         else step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
